proc_datapath: RTL
==================

Name: proc_datapath

Overview:
- 16-bit datapath driven directly by the processor control FSM; consumes its select, active-low load-enable and ALU controls each cycle.
- Holds register file R0..R7 (R7 is the PC), instruction register, A and G registers, the ALU, the shared bus mux, and ADDR/DOUT/W memory-side registers.
- Returns the instruction word to the FSM and drives the synchronous instruction/data memory.

Parameters:
- DATA_W, 16, width of bus, registers and memory words.
- PC_RESET, 16'h0000, value loaded into R7 on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  4  bus source: 0-7 = R0..R7, 8 = IR immediate, 9 = G, 10-15 = zero.
- RX_in  in  8  active-low per-register load enables; bit i loads Ri from the bus.
- IR_in  in  1  active-low; IR loads din.
- A_in  in  1  active-low; A loads the bus.
- G_in  in  1  active-low; G loads the ALU result.
- ADDR_in  in  1  active-low; ADDR loads the bus.
- PC_in  in  1  active-low; R7 loads the bus.
- pc_incr  in  1  active-high; R7 increments by 1.
- op  in  2  ALU class: 00 = add/sub, 01 = AND, others treated as 00.
- add_sub_ctrl  in  1  0 = add, 1 = subtract (A minus bus).
- W_inp  in  1  memory write request for the current cycle.
- din  in  16  memory read data.
- IR_out  out  16  instruction register, to the control FSM.
- addr  out  16  memory address (ADDR register).
- dout  out  16  memory write data (DOUT register).
- w  out  1  registered memory write enable.
- bus  out  16  current bus value, combinational, for debug.

Behaviour:
- Reset: R0..R6, A, G, IR, ADDR and DOUT clear to 0; R7 loads PC_RESET; w = 0. Reset overrides every enable in the same cycle.
- Bus mux (combinational):
  - sel 0-7 selects Ri.
  - sel 9 selects G.
  - sel 8 with IR[15:13] = 001 (MVT) gives {IR[7:0], 8'h00}.
  - sel 8 for any other opcode gives IR[8:0] zero-extended.
  - Undefined or X sel drives 16'h0000.
- ALU (combinational):
  - AND (A & bus) when op = 01 or IR[15:13] = 110.
  - Otherwise add (A + bus) or subtract (A - bus) per add_sub_ctrl.
  - Result is modulo 2^16; no carry or overflow output.
- Register writes (one-cycle latency; new value visible on the bus the cycle after the enabling edge):
  - Ri <= bus when RX_in[i] = 0.
  - A <= bus when A_in = 0; G <= ALU result when G_in = 0.
  - IR <= din when IR_in = 0; ADDR <= bus when ADDR_in = 0.
- PC (R7) priority, highest first:
  1. reset
  2. load from bus (RX_in[7] = 0 or PC_in = 0)
  3. increment (pc_incr = 1, wraps 16'hFFFF -> 16'h0000)
  4. hold
- Simultaneous load and pc_incr: load wins; no increment that cycle.
- Memory side: DOUT <= bus and w <= 1 when W_inp = 1; otherwise DOUT holds and w <= 0 (single-cycle pulse per request).
- Multiple RX_in bits low in one cycle: every selected register loads the same bus value.
- Register-to-self move (sel = i with RX_in[i] = 0) loads the pre-edge value, so the register is unchanged.
- A and G read-modify-write in one cycle is legal: the ALU uses pre-edge A.
- All enables inactive: all state holds; din is ignored.
- Reset asserted mid-instruction: everything returns to reset values on that edge; the partial instruction has no residual effect.

Test Plan:
- Reset then idle:
  - Hold reset 2 cycles with sel = 7 -> bus = 0000, addr = 0000, w = 0, IR_out = 0000.
  - 3 cycles of pc_incr = 1 -> R7 = 0003.
- Fetch and move immediate:
  - din = 16'h1205 with IR_in = 0 -> IR_out = 1205 next cycle.
  - sel = 8, RX_in = 8'b11111101 -> R1 = 0005.
- MVT:
  - IR = 16'h32AB, sel = 8, RX_in[1] = 0 -> R1 = AB00.
- ADD / SUB / AND with R0 = 0007, R1 = 0003:
  - sel = 0, A_in = 0; then sel = 1, G_in = 0, add_sub_ctrl = 0; then sel = 9, RX_in[0] = 0 -> R0 = 000A.
  - Repeat with add_sub_ctrl = 1 -> R0 = 0004.
  - Repeat with op = 01 -> R0 = 0003.
  - SUB with A = 0000 and bus = 0001 -> G = FFFF.
- PC priority and wrap:
  - R7 = FFFF with pc_incr = 1 -> 0000.
  - pc_incr = 1 with PC_in = 0 and bus = 0040 -> R7 = 0040, not 0041.
- Memory write and mid-instruction reset:
  - W_inp = 1 with sel = 2, R2 = BEEF -> dout = BEEF and w = 1 for exactly one cycle.
  - Reset asserted after the T3 A load -> A = 0000, R7 = PC_RESET, no register written afterwards.

Source files
------------

// File: rtl/proc_datapath.sv
// 16-bit processor datapath: register file R0..R7 (R7 = PC), IR, A, G, ALU, bus mux
// and the memory-side ADDR/DOUT/W registers, steered by active-low load enables.
module proc_datapath #(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        sel,
  input  logic [7:0]        RX_in,
  input  logic              IR_in,
  input  logic              A_in,
  input  logic              G_in,
  input  logic              ADDR_in,
  input  logic              PC_in,
  input  logic              pc_incr,
  input  logic [1:0]        op,
  input  logic              add_sub_ctrl,
  input  logic              W_inp,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] IR_out,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              w,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] ir_q, a_q, g_q, addr_q, dout_q;
  logic              w_q;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        ir_opcode;
  logic              is_and;

  assign ir_opcode = ir_q[DATA_W-1 -: 3];

  // Unknown sel falls to the default arm, so X selects drive zero as well.
  always_comb begin
    bus = '0;
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: bus = r_q[sel[2:0]];
      4'd8: begin
        if (ir_opcode == 3'b001) begin
          bus[DATA_W-1 -: 8] = ir_q[7:0];
        end else begin
          bus[8:0] = ir_q[8:0];
        end
      end
      4'd9:    bus = g_q;
      default: bus = '0;
    endcase
  end

  assign is_and = (op == 2'b01) || (ir_opcode == 3'b110);

  always_comb begin
    alu_res = '0;
    if (is_and) begin
      alu_res = a_q & bus;
    end else if (add_sub_ctrl) begin
      alu_res = a_q - bus;
    end else begin
      alu_res = a_q + bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) begin
        r_q[i] <= '0;
      end
      r_q[7] <= PC_RESET;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      addr_q <= '0;
      dout_q <= '0;
      w_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (!RX_in[i]) r_q[i] <= bus;
      end
      // A bus load of the PC beats the increment in the same cycle.
      if (!RX_in[7] || !PC_in) begin
        r_q[7] <= bus;
      end else if (pc_incr) begin
        r_q[7] <= r_q[7] + DATA_W'(1);
      end
      if (!IR_in)   ir_q   <= din;
      if (!A_in)    a_q    <= bus;
      if (!G_in)    g_q    <= alu_res;
      if (!ADDR_in) addr_q <= bus;
      if (W_inp)    dout_q <= bus;
      w_q <= W_inp;
    end
  end

  assign IR_out = ir_q;
  assign addr   = addr_q;
  assign dout   = dout_q;
  assign w      = w_q;

endmodule
